// File: rtl/countdown_timer_pkg.sv
// Shared types and defaults for the countdown timer slice.
// Optional feature macro used by this slice: TIMER_AUTO_RELOAD_EN.
package timer_pkg;

  localparam int WIDTH_DEF    = 32;
  localparam int PRESCALE_DEF = 50000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Counter width able to hold PRESCALE-1; never narrower than one bit.
  function automatic int prescale_width(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Software-facing strobe/status bundle of the countdown timer.
// master drives the strobes, slave is the timer itself.
interface countdown_timer_if
  import timer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             pause;
  logic [WIDTH-1:0] count;
  logic             running;
  logic             expired;
  logic             done;

  modport master (
    output load, load_val, start, pause,
    input  count, running, expired, done
  );

  modport slave (
    input  load, load_val, start, pause,
    output count, running, expired, done
  );
endinterface

// File: rtl/countdown_timer_tick_prescaler.sv
// PRESCALE-1..0 down-counter producing one enabled tick per PRESCALE
// enabled cycles. Holds its value while en is low so a paused run
// resumes mid-period.
module tick_prescaler
  import timer_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEF
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  input  logic reload,
  output logic tick
);
  localparam int            PW  = prescale_width(PRESCALE);
  localparam logic [PW-1:0] TOP = PW'(PRESCALE - 1);

  logic [PW-1:0] value;

  assign tick = en && (value == '0);

  // Reload wins over counting; wrap to TOP on each tick.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      value <= TOP;
    end else if (reload || tick) begin
      value <= TOP;
    end else if (en) begin
      value <= value - PW'(1);
    end
  end
endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with prescaler; one-cycle expired pulse on reaching 0.
// Optional feature macro: TIMER_AUTO_RELOAD_EN (reload on expiry, stay in RUN).
//
// state | meaning
// IDLE  | loaded or reset, waiting for start
// RUN   | prescaler active, count decrements once per PRESCALE cycles
// PAUSE | prescaler and count frozen, start resumes
// DONE  | count reached 0, only load or reset leaves
module countdown_timer
  import timer_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int PRESCALE = PRESCALE_DEF
) (
  input  logic                  clk,
  input  logic                  clr,
  countdown_timer_if.slave      bus
);
  state_t           state, state_nxt;
  logic [WIDTH-1:0] count_q;
  logic             running_q, done_q, expired_q;
  logic             running_d, done_d, expired_d;
  logic             tick_en, tick, last;
  logic             run_on;

`ifdef TIMER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q;

  // Reload value follows every load.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      reload_q <= '0;
    end else if (bus.load) begin
      reload_q <= bus.load_val;
    end
  end

  assign run_on = (reload_q != '0);
`else
  assign run_on = 1'b0;
`endif

  // Pause and load freeze the prescaler on the very edge they arrive.
  assign tick_en = (state == ST_RUN) && !bus.load && !bus.pause;
  assign last    = tick && (count_q == WIDTH'(1));

  tick_prescaler #(.PRESCALE(PRESCALE)) u_presc (
    .clk    (clk),
    .clr    (clr),
    .en     (tick_en),
    .reload (bus.load),
    .tick   (tick)
  );

  // State register and registered status outputs.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= ST_IDLE;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      running_q <= running_d;
      done_q    <= done_d;
      expired_q <= expired_d;
    end
  end

  // Next-state decode; priority load > pause > start.
  always_comb begin
    state_nxt = state;
    if (bus.load) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (bus.start) state_nxt = (count_q == '0) ? ST_DONE : ST_RUN;
        ST_RUN: begin
          if (bus.pause)  state_nxt = ST_PAUSE;
          else if (last)  state_nxt = run_on ? ST_RUN : ST_DONE;
        end
        ST_PAUSE: if (bus.start) state_nxt = ST_RUN;
        default:  state_nxt = ST_DONE;
      endcase
    end
  end

  // Output decode from the next state; expiry pulse suppressed by load.
  always_comb begin
    running_d = (state_nxt == ST_RUN);
    done_d    = (state_nxt == ST_DONE);
    expired_d = 1'b0;
    if (!bus.load) begin
      if (state == ST_IDLE && bus.start && count_q == '0) expired_d = 1'b1;
      if (state == ST_RUN && last)                        expired_d = 1'b1;
    end
  end

  // Count datapath: only ticks in RUN move it, and never below 0.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      count_q <= '0;
    end else if (bus.load) begin
      count_q <= bus.load_val;
    end else if (tick && count_q != '0) begin
`ifdef TIMER_AUTO_RELOAD_EN
      count_q <= last ? reload_q : count_q - WIDTH'(1);
`else
      count_q <= count_q - WIDTH'(1);
`endif
    end
  end

  assign bus.count   = count_q;
  assign bus.running = running_q;
  assign bus.done    = done_q;
  assign bus.expired = expired_q;
endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer (PRESCALE=4). Expected expiry
// edges are queued when start is driven and popped when expired is seen.
module tb_countdown_timer;
  localparam int W = 32;
  localparam int P = 4;

  logic clk = 1'b0;
  logic clr;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   exp_q[$];
  int   e, p, s, n;

  countdown_timer_if #(.WIDTH(W)) bus ();

  countdown_timer #(.WIDTH(W), .PRESCALE(P)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic l, input logic [W-1:0] v, input logic st, input logic pa);
    bus.load     = l;
    bus.load_val = v;
    bus.start    = st;
    bus.pause    = pa;
    @(posedge clk);
    #1;
    bus.load  = 1'b0;
    bus.start = 1'b0;
    bus.pause = 1'b0;
  endtask

  // Every expired pulse must match the head of the expected-edge queue.
  always @(negedge clk) begin
    if (clr && bus.expired) begin
      if (exp_q.size() == 0) check("unexpected_expired", 1, 0);
      else                   check("expired_edge", cyc, exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    clr          = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = '0;
    bus.start    = 1'b0;
    bus.pause    = 1'b0;
    step(3);
    check("rst_count",   bus.count,   0);
    check("rst_running", bus.running, 0);
    check("rst_done",    bus.done,    0);
    check("rst_expired", bus.expired, 0);
    clr = 1'b1;

    // Basic expiry
    strobe(1, 3, 0, 0);
    check("s1_load_count", bus.count, 3);
    strobe(0, 0, 1, 0);
    e = cyc;
    exp_q.push_back(e + 3 * P);
    check("s1_running", bus.running, 1);
    step(P - 1);
    check("s1_before_first_dec", bus.count, 3);
    step(1);
    check("s1_count_2", bus.count, 2);
    step(P);
    check("s1_count_1", bus.count, 1);
    step(P);
    check("s1_count_0",     bus.count,   0);
    check("s1_expired_hi",  bus.expired, 1);
    check("s1_done",        bus.done,    1);
    check("s1_running_off", bus.running, 0);
    step(1);
    check("s1_expired_lo", bus.expired, 0);

    // Pause and resume
    strobe(1, 5, 0, 0);
    strobe(0, 0, 1, 0);
    e = cyc;
    step(5);
    check("s2_count_before_pause", bus.count, 4);
    strobe(0, 0, 0, 1);
    p = cyc;
    check("s2_paused_running", bus.running, 0);
    for (int i = 0; i < 9; i++) begin
      if (i == 4) strobe(0, 0, 0, 1);
      else        step(1);
      check("s2_hold_count", bus.count, 4);
    end
    strobe(0, 0, 1, 0);
    s = cyc;
    n = 20 - (p - e - 1);
    exp_q.push_back(s + n);
    check("s2_resumed", bus.running, 1);
    step(n);
    check("s2_done",  bus.done,  1);
    check("s2_count", bus.count, 0);

    // Zero load and ignored strobes in DONE
    strobe(1, 0, 0, 0);
    strobe(0, 0, 1, 0);
    exp_q.push_back(cyc);
    check("s3_done",  bus.done,  1);
    check("s3_count", bus.count, 0);
    strobe(0, 0, 1, 0);
    strobe(0, 0, 0, 1);
    strobe(0, 0, 1, 1);
    step(5);
    check("s3_done_held",  bus.done,    1);
    check("s3_count_held", bus.count,   0);
    check("s3_not_run",    bus.running, 0);

    // Priority: load beats start and pause
    strobe(1, 5, 0, 0);
    strobe(0, 0, 1, 0);
    step(3);
    strobe(1, 9, 1, 1);
    check("s4_count_9",  bus.count,   9);
    check("s4_idle_run", bus.running, 0);
    check("s4_idle_dn",  bus.done,    0);
    step(10);
    check("s4_idle_hold", bus.count, 9);

    // Load on the expiry edge: no pulse
    strobe(1, 1, 0, 0);
    strobe(0, 0, 1, 0);
    step(P - 1);
    strobe(1, 6, 0, 0);
    check("s4_load_exp_count",   bus.count,   6);
    check("s4_load_exp_done",    bus.done,    0);
    check("s4_load_exp_running", bus.running, 0);
    check("s4_load_exp_pulse",   bus.expired, 0);
    step(3);
    check("s4_load_exp_idle", bus.done, 0);

    // Asynchronous reset mid-period
    strobe(1, 7, 0, 0);
    strobe(0, 0, 1, 0);
    step(5);
    #2;
    clr = 1'b0;
    #1;
    check("s5_async_count",   bus.count,   0);
    check("s5_async_running", bus.running, 0);
    check("s5_async_done",    bus.done,    0);
    step(3);
    clr = 1'b1;
    step(10);
    check("s5_no_count", bus.count,   0);
    check("s5_no_run",   bus.running, 0);
    strobe(1, 2, 0, 0);
    strobe(0, 0, 1, 0);
    e = cyc;
    exp_q.push_back(e + 2 * P);
`ifdef TIMER_AUTO_RELOAD_EN
    exp_q.push_back(e + 4 * P);
    exp_q.push_back(e + 6 * P);
    for (int k = 0; k < 3; k++) begin
      step(2 * P);
      check("s6_running", bus.running, 1);
      check("s6_reload",  bus.count,   2);
      check("s6_not_done", bus.done,   0);
    end
    strobe(1, 0, 0, 0);
`else
    step(2 * P);
    check("s6_done",    bus.done,    1);
    check("s6_running", bus.running, 0);
    check("s6_count",   bus.count,   0);
`endif

    step(5);
    check("pending_expiry", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
